// File: rtl/button_req_debounce_pkg.sv
// Shared definitions for push-button input blocks: debounce FSM state
// encoding and a counter-width helper.
package button_req_debounce_pkg;

  typedef enum logic [1:0] {
    BTN_RELEASED     = 2'd0,
    BTN_PRESS_WAIT   = 2'd1,
    BTN_PRESSED      = 2'd2,
    BTN_RELEASE_WAIT = 2'd3
  } btn_state_e;

  // Width that holds 0..max_count without wrapping.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return $clog2(max_count) + 1;
  endfunction

endpackage

// File: rtl/button_req_debounce_if.sv
// Button-side signal group: raw pin in, clean request/level/release out.
// slave = debouncer side, master = the block that owns the pin and consumes
// the requests.
interface button_req_debounce_if;
  logic i_btn;
  logic o_req;
  logic o_pressed;
  logic o_release;

  modport master (output i_btn, input o_req, input o_pressed, input o_release);
  modport slave  (input i_btn, output o_req, output o_pressed, output o_release);
endinterface

// File: rtl/button_req_debounce_sync_2ff.sv
// sync_2ff: 1-bit two-flop synchroniser with async active-high reset and a
// parameterised reset value, reusable for any asynchronous pin input.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic meta;

  // Two back-to-back flops to resolve metastability on the raw pin.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      meta <= RESET_VAL;
      o_q  <= RESET_VAL;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/button_req_debounce.sv
// button_req_debounce: raw bouncing push-button -> synchronised, debounced
// level (o_pressed), one-cycle press request (o_req) and one-cycle release
// pulse (o_release).
// Optional feature macro: BTN_AUTOREPEAT_EN adds a hold-to-repeat timer that
// re-issues o_req after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles.
module button_req_debounce
  import button_req_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned REPEAT_DELAY    = 12500000,
  parameter int unsigned REPEAT_PERIOD   = 6250000
) (
  input logic                  i_clk,
  input logic                  i_reset,
  button_req_debounce_if.slave bus
);

  localparam int unsigned          CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("button_req_debounce: DEBOUNCE_CYCLES must be >= 2, REPEAT_* >= 1");
  end

  logic             btn_sync;
  logic             p;
  btn_state_e       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             req_q, req_n;
  logic             rel_q, rel_n;
  logic             pressed_q, pressed_n;

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned      REP_W = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ?
                                                 REPEAT_DELAY : REPEAT_PERIOD);
  localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0] rep_cnt, rep_cnt_n;
  logic             rep_started, rep_started_n;
`endif

  // Reset value of the synchroniser is the pin's "released" level.
  sync_2ff #(
    .RESET_VAL(ACTIVE_LOW)
  ) u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (bus.i_btn),
    .o_q     (btn_sync)
  );

  assign p = ACTIVE_LOW ? ~btn_sync : btn_sync;

  // State, stability counter, repeat timer and registered outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= BTN_RELEASED;
      cnt         <= '0;
      req_q       <= 1'b0;
      rel_q       <= 1'b0;
      pressed_q   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rep_cnt     <= '0;
      rep_started <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      req_q       <= req_n;
      rel_q       <= rel_n;
      pressed_q   <= pressed_n;
`ifdef BTN_AUTOREPEAT_EN
      rep_cnt     <= rep_cnt_n;
      rep_started <= rep_started_n;
`endif
    end
  end

  // Next-state, counter and pulse decode.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    req_n     = 1'b0;
    rel_n     = 1'b0;
    pressed_n = pressed_q;
`ifdef BTN_AUTOREPEAT_EN
    // Timer is held at zero everywhere except while staying in PRESSED, so
    // any entry into PRESSED starts a fresh REPEAT_DELAY wait.
    rep_cnt_n     = '0;
    rep_started_n = 1'b0;
`endif
    case (state)
      BTN_RELEASED: begin
        if (p) begin
          state_n = BTN_PRESS_WAIT;
          cnt_n   = '0;
        end
      end
      BTN_PRESS_WAIT: begin
        if (!p) begin
          state_n = BTN_RELEASED;
        end else if (cnt == CNT_LAST) begin
          state_n   = BTN_PRESSED;
          req_n     = 1'b1;
          pressed_n = 1'b1;
        end else if (cnt != '1) begin
          cnt_n = cnt + 1'b1;
        end
      end
      BTN_PRESSED: begin
        if (!p) begin
          state_n = BTN_RELEASE_WAIT;
          cnt_n   = '0;
        end else begin
`ifdef BTN_AUTOREPEAT_EN
          rep_started_n = rep_started;
          if (rep_cnt == (rep_started ? REP_PERIOD_LAST : REP_DELAY_LAST)) begin
            req_n         = 1'b1;
            rep_cnt_n     = '0;
            rep_started_n = 1'b1;
          end else begin
            rep_cnt_n = rep_cnt + 1'b1;
          end
`endif
        end
      end
      BTN_RELEASE_WAIT: begin
        if (p) begin
          state_n = BTN_PRESSED;
        end else if (cnt == CNT_LAST) begin
          state_n   = BTN_RELEASED;
          pressed_n = 1'b0;
          rel_n     = 1'b1;
        end else if (cnt != '1) begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = BTN_RELEASED;
    endcase
  end

  assign bus.o_req     = req_q;
  assign bus.o_release = rel_q;
  assign bus.o_pressed = pressed_q;

endmodule

// File: tb/tb_button_req_debounce.sv
// Directed bench for button_req_debounce (DEBOUNCE_CYCLES=4, active-low pin,
// REPEAT_DELAY=10, REPEAT_PERIOD=5). A negedge monitor logs the cycle numbers
// of o_req / o_release pulses and o_pressed changes; each test compares those
// logs against hand-derived cycle numbers.
module tb_button_req_debounce;

  logic i_clk = 1'b0;
  logic i_reset;

  always #5 i_clk = ~i_clk;

  button_req_debounce_if bus();

  button_req_debounce #(
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW(1'b1),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(5)
  ) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   req_q[$];
  int   rel_q[$];
  int   chg_q[$];
  logic prev_pressed = 1'b0;
  bit   overlap = 1'b0;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (bus.o_req === 1'b1) req_q.push_back(cyc);
    if (bus.o_release === 1'b1) rel_q.push_back(cyc);
    if (bus.o_req === 1'b1 && bus.o_release === 1'b1) overlap = 1'b1;
    if (bus.o_pressed !== prev_pressed) chg_q.push_back(cyc);
    prev_pressed = bus.o_pressed;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic clear_logs;
    req_q.delete();
    rel_q.delete();
    chg_q.delete();
  endtask

  task automatic test_reset;
    i_reset   = 1'b1;
    bus.i_btn = 1'b1;
    tick(3);
    tests++;
    if (bus.o_req !== 1'b0) begin
      fails++; $display("FAIL reset_o_req: got %b expected 0", bus.o_req);
    end
    tests++;
    if (bus.o_pressed !== 1'b0) begin
      fails++; $display("FAIL reset_o_pressed: got %b expected 0", bus.o_pressed);
    end
    tests++;
    if (bus.o_release !== 1'b0) begin
      fails++; $display("FAIL reset_o_release: got %b expected 0", bus.o_release);
    end
    i_reset = 1'b0;
    tick(3);
    clear_logs();
  endtask

  task automatic test_clean_press;
    int k;
    int exp_req[$];
    clear_logs();
    bus.i_btn = 1'b0;
    k = cyc + 1;
    tick(20);
`ifdef BTN_AUTOREPEAT_EN
    exp_req = '{k + 6, k + 16};
`else
    exp_req = '{k + 6};
`endif
    tests++;
    if (req_q.size() != exp_req.size()) begin
      fails++; $display("FAIL press_req_count: got %0d expected %0d", req_q.size(), exp_req.size());
    end
    for (int i = 0; i < exp_req.size(); i++) begin
      int act;
      act = (i < req_q.size()) ? req_q[i] : -1;
      tests++;
      if (act != exp_req[i]) begin
        fails++; $display("FAIL press_req_cycle[%0d]: got %0d expected %0d", i, act, exp_req[i]);
      end
    end
    tests++;
    if (chg_q.size() != 1 || chg_q[0] != k + 6) begin
      fails++; $display("FAIL press_pressed_rise: got %0d changes expected 1 at %0d", chg_q.size(), k + 6);
    end
    tests++;
    if (bus.o_pressed !== 1'b1) begin
      fails++; $display("FAIL press_level: got %b expected 1", bus.o_pressed);
    end
    tests++;
    if (rel_q.size() != 0) begin
      fails++; $display("FAIL press_no_release: got %0d pulses expected 0", rel_q.size());
    end
  endtask

  task automatic test_release;
    int r;
    clear_logs();
    bus.i_btn = 1'b1;
    r = cyc + 1;
    tick(15);
    tests++;
    if (rel_q.size() != 1 || rel_q[0] != r + 6) begin
      fails++; $display("FAIL release_pulse: got %0d pulses expected 1 at %0d", rel_q.size(), r + 6);
    end
    tests++;
    if (chg_q.size() != 1 || chg_q[0] != r + 6) begin
      fails++; $display("FAIL release_pressed_fall: got %0d changes expected 1 at %0d", chg_q.size(), r + 6);
    end
`ifdef BTN_AUTOREPEAT_EN
    tests++;
    if (req_q.size() != 1 || req_q[0] != r + 1) begin
      fails++; $display("FAIL release_req: got %0d pulses expected 1 repeat at %0d", req_q.size(), r + 1);
    end
`else
    tests++;
    if (req_q.size() != 0) begin
      fails++; $display("FAIL release_req: got %0d pulses expected 0", req_q.size());
    end
`endif
    tests++;
    if (bus.o_pressed !== 1'b0) begin
      fails++; $display("FAIL release_level: got %b expected 0", bus.o_pressed);
    end
  endtask

  task automatic test_bounce;
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      bus.i_btn = 1'b0;
      tick(2);
      bus.i_btn = 1'b1;
      tick(2);
    end
    tick(10);
    tests++;
    if (req_q.size() != 0) begin
      fails++; $display("FAIL bounce_req: got %0d pulses expected 0", req_q.size());
    end
    tests++;
    if (rel_q.size() != 0) begin
      fails++; $display("FAIL bounce_release: got %0d pulses expected 0", rel_q.size());
    end
    tests++;
    if (chg_q.size() != 0 || bus.o_pressed !== 1'b0) begin
      fails++; $display("FAIL bounce_level: got %0d changes, level %b expected 0 changes, level 0", chg_q.size(), bus.o_pressed);
    end
  endtask

  task automatic test_release_bounce;
    int k;
    int r;
    clear_logs();
    bus.i_btn = 1'b0;
    k = cyc + 1;
    tick(9);
    tests++;
    if (req_q.size() != 1 || req_q[0] != k + 6) begin
      fails++; $display("FAIL rb_press_req: got %0d pulses expected 1 at %0d", req_q.size(), k + 6);
    end
    clear_logs();
    bus.i_btn = 1'b1;
    r = cyc + 1;
    tick(3);
    bus.i_btn = 1'b0;
    tick(1);
    bus.i_btn = 1'b1;
    tick(12);
    tests++;
    if (req_q.size() != 0) begin
      fails++; $display("FAIL rb_extra_req: got %0d pulses expected 0", req_q.size());
    end
    tests++;
    if (rel_q.size() != 1 || rel_q[0] != r + 10) begin
      fails++; $display("FAIL rb_release: got %0d pulses expected 1 at %0d", rel_q.size(), r + 10);
    end
    tests++;
    if (chg_q.size() != 1 || chg_q[0] != r + 10) begin
      fails++; $display("FAIL rb_pressed_fall: got %0d changes expected 1 at %0d", chg_q.size(), r + 10);
    end
  endtask

  task automatic test_reset_mid_press;
    int e;
    clear_logs();
    bus.i_btn = 1'b0;
    tick(9);
    tests++;
    if (bus.o_pressed !== 1'b1) begin
      fails++; $display("FAIL rst_pre_pressed: got %b expected 1", bus.o_pressed);
    end
    i_reset = 1'b1;
    #2;
    tests++;
    if (bus.o_pressed !== 1'b0 || bus.o_req !== 1'b0 || bus.o_release !== 1'b0) begin
      fails++; $display("FAIL rst_async_outputs: got pressed=%b req=%b rel=%b expected 0 0 0", bus.o_pressed, bus.o_req, bus.o_release);
    end
    tick(2);
    i_reset = 1'b0;
    clear_logs();
    e = cyc + 1;
    tick(9);
    tests++;
    if (req_q.size() != 1 || req_q[0] != e + 6) begin
      fails++; $display("FAIL rst_requalify_req: got %0d pulses expected 1 at %0d", req_q.size(), e + 6);
    end
    tests++;
    if (chg_q.size() != 1 || chg_q[0] != e + 6) begin
      fails++; $display("FAIL rst_requalify_level: got %0d changes expected 1 at %0d", chg_q.size(), e + 6);
    end
    bus.i_btn = 1'b1;
    tick(12);
    tests++;
    if (bus.o_pressed !== 1'b0) begin
      fails++; $display("FAIL rst_final_release: got %b expected 0", bus.o_pressed);
    end
  endtask

  task automatic test_autorepeat;
    int t0;
    int exp_req[$];
    clear_logs();
    bus.i_btn = 1'b0;
    t0 = cyc + 1 + 6;
    tick(t0 + 30 - cyc);
    bus.i_btn = 1'b1;
    tick(15);
`ifdef BTN_AUTOREPEAT_EN
    exp_req = '{t0, t0 + 10, t0 + 15, t0 + 20, t0 + 25, t0 + 30};
`else
    exp_req = '{t0};
`endif
    tests++;
    if (req_q.size() != exp_req.size()) begin
      fails++; $display("FAIL hold_req_count: got %0d expected %0d", req_q.size(), exp_req.size());
    end
    for (int i = 0; i < exp_req.size(); i++) begin
      int act;
      act = (i < req_q.size()) ? req_q[i] : -1;
      tests++;
      if (act != exp_req[i]) begin
        fails++; $display("FAIL hold_req_cycle[%0d]: got %0d expected %0d", i, act, exp_req[i]);
      end
    end
    tests++;
    if (rel_q.size() != 1 || rel_q[0] != t0 + 37) begin
      fails++; $display("FAIL hold_release: got %0d pulses expected 1 at %0d", rel_q.size(), t0 + 37);
    end
  endtask

  task automatic test_no_overlap;
    tests++;
    if (overlap !== 1'b0) begin
      fails++; $display("FAIL req_release_overlap: got %b expected 0", overlap);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_release_bounce();
    test_reset_mid_press();
    test_autorepeat();
    test_no_overlap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
